// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// MULT/MULTU/DIV/DIVU run one radix-2 step per cycle; MTHI/MTLO write directly.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiply path).
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned DW = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [DW-1:0]    acc, acc_n;        // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0] opnd, opnd_n;      // mul: multiplicand magnitude; div: divisor magnitude
    logic             is_div, is_div_n;
    logic             neg_res, neg_res_n; // product / quotient negative
    logic             neg_a, neg_a_n;     // remainder takes dividend sign
    logic [WIDTH-1:0] hi_n, lo_n;
    logic             busy_n, done_n, dbz_n;

    logic             op_signed_c;
    logic             sign_a_c, sign_b_c;
    logic [WIDTH-1:0] mag_a_c, mag_b_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_shift_c;
    logic [WIDTH-1:0] div_diff_c;
    logic             div_ge_c;
    logic [DW-1:0]    prod_fix_c;
    logic [WIDTH-1:0] quo_c, rem_c;

    // Operand magnitudes and one radix-2 step for each datapath
    always_comb begin
        op_signed_c = (op == OP_MULT) || (op == OP_DIV);
        sign_a_c    = op_signed_c & src_a[WIDTH-1];
        sign_b_c    = op_signed_c & src_b[WIDTH-1];
        mag_a_c     = sign_a_c ? (WIDTH'(0) - src_a) : src_a;
        mag_b_c     = sign_b_c ? (WIDTH'(0) - src_b) : src_b;

        mul_sum_c   = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : (WIDTH+1)'(0));

        div_shift_c = {acc[DW-1:WIDTH], acc[WIDTH-1]};
        div_ge_c    = div_shift_c >= {1'b0, opnd};
        div_diff_c  = div_shift_c[WIDTH-1:0] - opnd;

        prod_fix_c  = neg_res ? (DW'(0) - acc) : acc;
        quo_c       = acc[WIDTH-1:0];
        rem_c       = acc[DW-1:WIDTH];
    end

    // Next-state and next-register logic; cancel overrides everything
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        acc_n     = acc;
        opnd_n    = opnd;
        is_div_n  = is_div;
        neg_res_n = neg_res;
        neg_a_n   = neg_a;
        hi_n      = hi;
        lo_n      = lo;
        done_n    = 1'b0;
        dbz_n     = 1'b0;

        case (state)
            IDLE: begin
                if (start && !cancel && !busy) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            is_div_n  = 1'b0;
                            neg_res_n = sign_a_c ^ sign_b_c;
                            neg_a_n   = sign_a_c;
                            opnd_n    = mag_a_c;
                            cnt_n     = '0;
`ifdef MULDIV_FAST_MUL_EN
                            acc_n     = DW'(mag_a_c) * DW'(mag_b_c);
                            state_n   = FINISH;
`else
                            acc_n     = {WIDTH'(0), mag_b_c};
                            state_n   = RUN;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            is_div_n  = 1'b1;
                            neg_res_n = sign_a_c ^ sign_b_c;
                            neg_a_n   = sign_a_c;
                            opnd_n    = mag_b_c;
                            acc_n     = {WIDTH'(0), mag_a_c};
                            cnt_n     = '0;
                            state_n   = RUN;
                        end
                        OP_MTHI: hi_n = src_a;
                        OP_MTLO: lo_n = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cancel) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    if (is_div) begin
                        acc_n = {(div_ge_c ? div_diff_c : div_shift_c[WIDTH-1:0]),
                                 acc[WIDTH-2:0], div_ge_c};
                    end else begin
                        acc_n = {mul_sum_c, acc[WIDTH-1:1]};
                    end
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state_n = FINISH;
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
                cnt_n   = '0;
                if (!cancel) begin
                    done_n = 1'b1;
                    if (is_div) begin
                        dbz_n = (opnd == WIDTH'(0));
                        // Divide by zero: remainder already equals the dividend
                        lo_n  = dbz_n ? {WIDTH{1'b1}} : (neg_res ? (WIDTH'(0) - quo_c) : quo_c);
                        hi_n  = neg_a ? (WIDTH'(0) - rem_c) : rem_c;
                    end else begin
                        hi_n  = prod_fix_c[DW-1:WIDTH];
                        lo_n  = prod_fix_c[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // busy covers the whole operation including the done cycle
        busy_n = (state_n != IDLE) || done_n;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_a       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            acc         <= acc_n;
            opnd        <= opnd_n;
            is_div      <= is_div_n;
            neg_res     <= neg_res_n;
            neg_a       <= neg_a_n;
            hi          <= hi_n;
            lo          <= lo_n;
            busy        <= busy_n;
            done        <= done_n;
            div_by_zero <= dbz_n;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DIV_LAT = 33;
`ifdef MULDIV_FAST_MUL_EN
    localparam int unsigned MUL_LAT = 1;
`else
    localparam int unsigned MUL_LAT = 33;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int pass_cnt = 0;
    int total    = 0;

    muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op and wait for done; lat = posedges after the start edge
    task automatic issue_and_wait(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output int lat, output bit seen, output bit busy_early);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        busy_early = busy;
        n    = 0;
        seen = done;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            seen = done;
        end
        lat = n;
    endtask

    task automatic check_arith(input string name, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                               input logic [31:0] exp_lo, input logic exp_dbz);
        int lat;
        bit seen, be;
        issue_and_wait(o, a, b, lat, seen, be);
        total++;
        if (!seen || lat != exp_lat) $display("FAIL %s latency: got %0d (seen=%0d) want %0d", name, lat, seen, exp_lat);
        else pass_cnt++;
        total++;
        if (hi !== exp_hi || lo !== exp_lo)
            $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
        else pass_cnt++;
        total++;
        if (div_by_zero !== exp_dbz || busy !== 1'b1 || be !== 1'b1)
            $display("FAIL %s flags: got dbz=%b busy=%b busy_early=%b want dbz=%b busy=1 busy_early=1",
                     name, div_by_zero, busy, be, exp_dbz);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b0)
            $display("FAIL %s after: got done=%b busy=%b dbz=%b want 0 0 0", name, done, busy, div_by_zero);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0; cancel = 1'b0;
        #12;
        total++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0)
            $display("FAIL reset: got hi=%h lo=%h busy=%b done=%b dbz=%b want zeros", hi, lo, busy, done, div_by_zero);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult();
        check_arith("mult_neg3x7", 3'd0, 32'hFFFFFFFD, 32'd7, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        check_arith("mult_neg_neg", 3'd0, 32'hFFFFFFFE, 32'hFFFFFFFD, MUL_LAT, 32'h0, 32'd6, 1'b0);
        check_arith("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    endtask

    task automatic test_div();
        check_arith("div_neg7_2", 3'd2, 32'hFFFFFFF9, 32'd2, DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        check_arith("div_7_neg2", 3'd2, 32'd7, 32'hFFFFFFFE, DIV_LAT, 32'd1, 32'hFFFFFFFD, 1'b0);
        check_arith("divu_100_7", 3'd3, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14, 1'b0);
    endtask

    task automatic test_div_corner();
        check_arith("divu_by_zero", 3'd3, 32'h1234, 32'h0, DIV_LAT, 32'h1234, 32'hFFFFFFFF, 1'b1);
        check_arith("div_neg_by_zero", 3'd2, 32'hFFFFFFF0, 32'h0, DIV_LAT, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);
        check_arith("div_min_neg1", 3'd2, 32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'h0, 32'h80000000, 1'b0);
    endtask

    task automatic test_cancel();
        bit seen;
        // prior result from div_min_neg1: hi=0, lo=0x80000000
        @(negedge clk);
        start = 1'b1; op = 3'd2; src_a = 32'd50; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL cancel_busy: got busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total++;
        if (seen || hi !== 32'h0 || lo !== 32'h80000000)
            $display("FAIL cancel_result: got done_seen=%0d hi=%h lo=%h want 0 00000000 80000000", seen, hi, lo);
        else pass_cnt++;
        // cancel in IDLE suppresses start
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 3'd3; src_a = 32'd9; src_b = 32'd2;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL cancel_idle: got busy=%b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int  n;
        bit  seen, extra;
        @(negedge clk);
        start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd1; src_a = 32'd3; src_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        n    = 5;
        seen = done;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            seen = done;
        end
        total++;
        if (!seen || n != DIV_LAT || hi !== 32'd2 || lo !== 32'd14)
            $display("FAIL busy_start_ignored: got lat=%0d hi=%h lo=%h want lat=%0d hi=2 lo=14", n, hi, lo, DIV_LAT);
        else pass_cnt++;
        extra = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) extra = 1'b1;
        end
        total++;
        if (extra || hi !== 32'd2 || lo !== 32'd14)
            $display("FAIL second_op_dropped: got extra=%0d hi=%h lo=%h want 0 2 14", extra, hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_mthi_mtlo();
        bit b_seen;
        b_seen = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'd4; src_a = 32'hCAFE;
        @(negedge clk);
        if (busy) b_seen = 1'b1;
        total++;
        if (hi !== 32'hCAFE || lo !== 32'd14)
            $display("FAIL mthi: got hi=%h lo=%h want 0000cafe 0000000e", hi, lo);
        else pass_cnt++;
        op = 3'd5; src_a = 32'hBEEF;
        @(negedge clk);
        if (busy || done) b_seen = 1'b1;
        op = 3'd6; src_a = 32'h1111;
        @(negedge clk);
        if (busy || done) b_seen = 1'b1;
        op = 3'd7;
        @(negedge clk);
        if (busy || done) b_seen = 1'b1;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (b_seen || hi !== 32'hCAFE || lo !== 32'hBEEF)
            $display("FAIL mtlo_noop: got busy_or_done=%0d hi=%h lo=%h want 0 0000cafe 0000beef", b_seen, hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bit seen;
        @(negedge clk);
        start = 1'b1; op = 3'd2; src_a = 32'd77; src_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL async_reset: got hi=%h lo=%h busy=%b done=%b want 0 0 0 0", hi, lo, busy, done);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen || hi !== 32'h0 || lo !== 32'h0)
            $display("FAIL reset_discard: got activity=%0d hi=%h lo=%h want 0 0 0", seen, hi, lo);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_corner();
        test_cancel();
        test_back_to_back();
        test_mthi_mtlo();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
